// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V definitions for the front end of the core.
//   - Base opcode constants (instr[6:0]) for the supported instruction classes.
//   - Immediate-format select encodings, shared with the immediate generator.
//   - IF/ID skid-buffer state type and the per-entry pre-decoded record.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // The immediate generator produces zero for IMM_SEL_NONE.
    localparam logic [2:0] IMM_SEL_I    = 3'd0;
    localparam logic [2:0] IMM_SEL_S    = 3'd1;
    localparam logic [2:0] IMM_SEL_SB   = 3'd2;
    localparam logic [2:0] IMM_SEL_U    = 3'd3;
    localparam logic [2:0] IMM_SEL_UJ   = 3'd4;
    localparam logic [2:0] IMM_SEL_NONE = 3'd7;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // One buffered instruction with its decode computed at capture time.
    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  imm_sel;
        logic        uses_imm;
        logic        illegal;
    } decoded_t;

    // Value held by an entry register while in reset: all zero, no immediate.
    function automatic decoded_t decoded_reset();
        decoded_t d;
        d          = '0;
        d.imm_sel  = IMM_SEL_NONE;
        return d;
    endfunction

endpackage

// File: rtl/instr_predecode.sv
// ---------------------------------------------------------------------------
// instr_predecode
// Combinational opcode classifier used on the IF/ID push path.
// Ports:
//   opcode   in  7  instr[6:0] of the instruction being captured
//   imm_sel  out 3  immediate format for the immediate generator
//   uses_imm out 1  instruction consumes an immediate
//   illegal  out 1  unsupported opcode (includes instr[1:0] != 2'b11)
// ---------------------------------------------------------------------------
module instr_predecode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic       uses_imm,
    output logic       illegal
);

    // Every supported opcode ends in 2'b11, so compressed/invalid encodings
    // naturally fall into the default branch and are flagged illegal.
    always_comb begin
        imm_sel  = IMM_SEL_NONE;
        uses_imm = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE: begin
                imm_sel  = IMM_SEL_I;
                uses_imm = 1'b1;
            end
            OPC_STORE: begin
                imm_sel  = IMM_SEL_S;
                uses_imm = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel  = IMM_SEL_SB;
                uses_imm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_sel  = IMM_SEL_U;
                uses_imm = 1'b1;
            end
            OPC_JAL: begin
                imm_sel  = IMM_SEL_UJ;
                uses_imm = 1'b1;
            end
            OPC_OP: begin
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/if_id_decode.sv
// ---------------------------------------------------------------------------
// if_id_decode
// IF/ID pipeline stage: 2-entry skid buffer with decode done at capture, so
// every output comes straight from a register.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          fetch handshake; in_ready depends on state only
//   in_instr, in_pc            instruction word and its PC
//   flush                      synchronous kill of all buffered entries
//   out_valid/out_ready        downstream handshake on the head entry
//   out_imm_field, out_imm_sel instr[31:7] and format select for the imm gen
//   out_pc                     PC of the head entry
//   out_rd/rs1/rs2/funct3/opcode  raw register and function fields
//   out_uses_imm, out_illegal  pre-decoded flags of the head entry
// ---------------------------------------------------------------------------
module if_id_decode
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit RESET_PC_VALID = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [24:0]     out_imm_field,
    output logic [2:0]      out_imm_sel,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_opcode,
    output logic            out_uses_imm,
    output logic            out_illegal
);

    // Injecting an instruction at reset is not supported; the parameter only
    // exists for interface compatibility and must stay 0.
    if (RESET_PC_VALID != 1'b0) begin : g_reset_pc_valid_unsupported
    end

    buf_state_t      state;
    buf_state_t      next_state;
    decoded_t        head_q;
    decoded_t        tail_q;
    logic [XLEN-1:0] head_pc_q;
    logic [XLEN-1:0] tail_pc_q;
    decoded_t        in_dec;
    logic            push;
    logic            pop;

    assign in_ready  = (state != BUF_TWO);
    assign out_valid = (state != BUF_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    instr_predecode u_predecode (
        .opcode   (in_instr[6:0]),
        .imm_sel  (in_dec.imm_sel),
        .uses_imm (in_dec.uses_imm),
        .illegal  (in_dec.illegal)
    );
    assign in_dec.instr = in_instr;

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy transitions; flush overrides any push/pop in the same cycle.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: if (push) next_state = BUF_ONE;
                BUF_ONE: begin
                    if (push && !pop)      next_state = BUF_TWO;
                    else if (pop && !push) next_state = BUF_EMPTY;
                end
                BUF_TWO:   if (pop) next_state = BUF_ONE;
                default:   next_state = BUF_EMPTY;
            endcase
        end
    end

    // Entry storage. The head register drives the outputs directly; the tail
    // only fills when the head is occupied and not leaving this cycle, and
    // shifts forward when the head is consumed from the full state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= decoded_reset();
            tail_q    <= decoded_reset();
            head_pc_q <= '0;
            tail_pc_q <= '0;
        end else if (!flush) begin
            case (state)
                BUF_EMPTY: begin
                    if (push) begin
                        head_q    <= in_dec;
                        head_pc_q <= in_pc;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        head_q    <= in_dec;
                        head_pc_q <= in_pc;
                    end else if (push) begin
                        tail_q    <= in_dec;
                        tail_pc_q <= in_pc;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        head_q    <= tail_q;
                        head_pc_q <= tail_pc_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_imm_field = head_q.instr[31:7];
    assign out_imm_sel   = head_q.imm_sel;
    assign out_pc        = head_pc_q;
    assign out_rd        = head_q.instr[11:7];
    assign out_rs1       = head_q.instr[19:15];
    assign out_rs2       = head_q.instr[24:20];
    assign out_funct3    = head_q.instr[14:12];
    assign out_opcode    = head_q.instr[6:0];
    assign out_uses_imm  = head_q.uses_imm;
    assign out_illegal   = head_q.illegal;

endmodule

// File: tb/tb_if_id_decode.sv
// ---------------------------------------------------------------------------
// tb_if_id_decode
// Self-checking bench for if_id_decode: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_if_id_decode;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [24:0]     out_imm_field;
    logic [2:0]      out_imm_sel;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_opcode;
    logic            out_uses_imm;
    logic            out_illegal;

    int     checkCount = 0;
    int     errorCount = 0;
    entry_t model[$];

    if_id_decode #(.XLEN(XLEN), .RESET_PC_VALID(1'b0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_imm_field (out_imm_field),
        .out_imm_sel   (out_imm_sel),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_opcode    (out_opcode),
        .out_uses_imm  (out_uses_imm),
        .out_illegal   (out_illegal)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference decode: format table by opcode value.
    function automatic void refDecode(input logic [31:0] w, output logic [2:0] sel,
                                      output logic uses, output logic ill);
        sel  = 3'd7;
        uses = 1'b0;
        ill  = 1'b0;
        if (w[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (w[6:0])
                7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin sel = 3'd0; uses = 1'b1; end
                7'h23:                             begin sel = 3'd1; uses = 1'b1; end
                7'h63:                             begin sel = 3'd2; uses = 1'b1; end
                7'h37, 7'h17:                      begin sel = 3'd3; uses = 1'b1; end
                7'h6F:                             begin sel = 3'd4; uses = 1'b1; end
                7'h33:                             begin end
                default:                           ill = 1'b1;
            endcase
        end
    endfunction

    // Compare every output against the model's view of the buffer.
    task automatic compareModel();
        logic [2:0] sel;
        logic       uses;
        logic       ill;
        entry_t     e;
        checkOutput("in_ready", in_ready, model.size() < 2);
        checkOutput("out_valid", out_valid, model.size() != 0);
        if (model.size() != 0) begin
            e = model[0];
            refDecode(e.instr, sel, uses, ill);
            checkOutput("out_pc", out_pc, e.pc);
            checkOutput("imm_field", out_imm_field, e.instr >> 7);
            checkOutput("imm_sel", out_imm_sel, sel);
            checkOutput("rd", out_rd, (e.instr >> 7) & 32'h1F);
            checkOutput("rs1", out_rs1, (e.instr >> 15) & 32'h1F);
            checkOutput("rs2", out_rs2, (e.instr >> 20) & 32'h1F);
            checkOutput("funct3", out_funct3, (e.instr >> 12) & 32'h7);
            checkOutput("opcode", out_opcode, e.instr & 32'h7F);
            checkOutput("uses_imm", out_uses_imm, uses);
            checkOutput("illegal", out_illegal, ill);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [XLEN-1:0] pc, input logic rdy,
                                 input logic fl);
        bit     doPush;
        bit     doPop;
        entry_t e;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        doPush    = v && (model.size() < 2);
        doPop     = rdy && (model.size() != 0);
        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (doPop) void'(model.pop_front());
            if (doPush) begin
                e.instr = instr;
                e.pc    = pc;
                model.push_back(e);
            end
        end
        @(negedge clk);
        compareModel();
    endtask

    task automatic checkReset();
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_imm_sel", out_imm_sel, 3'd7);
        checkOutput("rst_imm_field", out_imm_field, 25'd0);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_regs", {out_rd, out_rs1, out_rs2, out_funct3, out_opcode}, 25'd0);
        checkOutput("rst_flags", {out_uses_imm, out_illegal}, 2'b00);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    logic [31:0] streamInstr [4] = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h000000EF};
    logic [2:0]  streamSel   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [6:0]  legalOpc    [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23,
                                      7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset();
        rst_n = 1'b1;

        // addi x1,x0,5
        applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
        checkOutput("addi_valid", out_valid, 1'b1);
        checkOutput("addi_sel", out_imm_sel, 3'd0);
        checkOutput("addi_rd", out_rd, 5'd1);
        checkOutput("addi_imm_field", out_imm_field, 25'h000A001);

        // Back-to-back S/SB/U/UJ stream.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, streamInstr[i], 32'(4 * i), 1'b1, 1'b0);
            checkOutput("stream_sel", out_imm_sel, streamSel[i]);
            checkOutput("stream_pc", out_pc, 32'(4 * i));
        end

        // All-zero word is illegal; add is legal with no immediate.
        applyStimulus(1'b1, 32'h00000000, 32'h10, 1'b1, 1'b0);
        checkOutput("zero_illegal", out_illegal, 1'b1);
        checkOutput("zero_sel", out_imm_sel, 3'd7);
        applyStimulus(1'b1, 32'h002081B3, 32'h14, 1'b1, 1'b0);
        checkOutput("add_illegal", out_illegal, 1'b0);
        checkOutput("add_uses_imm", out_uses_imm, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: only two of three are accepted.
        applyStimulus(1'b1, 32'h00100113, 32'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200193, 32'h24, 1'b0, 1'b0);
        checkOutput("full_in_ready", in_ready, 1'b0);
        applyStimulus(1'b1, 32'h00300213, 32'h28, 1'b0, 1'b0);
        checkOutput("full_head_pc", out_pc, 32'h20);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h00300213, 32'h28, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a push offered.
        applyStimulus(1'b1, 32'h00100113, 32'h30, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200193, 32'h34, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00400293, 32'h38, 1'b0, 1'b1);
        checkOutput("flush_valid", out_valid, 1'b0);
        checkOutput("flush_in_ready", in_ready, 1'b1);
        // Flush in ONE with a push: the push is discarded too.
        applyStimulus(1'b1, 32'h00500313, 32'h3C, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600393, 32'h40, 1'b1, 1'b1);
        checkOutput("flush_one_valid", out_valid, 1'b0);

        // Asynchronous reset between edges.
        applyStimulus(1'b1, 32'h00100113, 32'h50, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200193, 32'h54, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkReset();
        model.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h00500093, 32'h0, 1'b1, 1'b0);
        checkOutput("post_rst_sel", out_imm_sel, 3'd0);
        checkOutput("post_rst_rd", out_rd, 5'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) != 0) w = {r[31:7], legalOpc[$urandom_range(0, 10)]};
            else w = $urandom();
            applyStimulus($urandom_range(0, 9) < 7, w, $urandom(),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
